dds_voice_scheduler: RTL

//  Time-shares one note/pitch-to-DDS converter among NVOICES polyphonic voices.

---
 rtl/synth_pkg.sv | 9 +
 rtl/dds_voice_scheduler_if.sv | 11 +
 rtl/rr_pick.sv | 26 ++
 rtl/dds_voice_scheduler.sv | 115 +++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared widths, pitch-wheel centre and scheduler state encoding for the synth voice path.
package synth_pkg;
    localparam int NOTE_W  = 7;
    localparam int PITCH_W = 14;
    localparam int ADDER_W = 32;
    localparam logic [PITCH_W-1:0] PITCH_CENTRE = 14'd8192;

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, CAPTURE} sched_state_t;
endpackage

// File: rtl/dds_voice_scheduler_if.sv
// Bus between the voice scheduler and the shared note/pitch-to-DDS converter.
interface dds_voice_scheduler_if;
    import synth_pkg::*;

    logic [NOTE_W-1:0]  cv_note;
    logic [PITCH_W-1:0] cv_pitch;
    logic [ADDER_W-1:0] cv_adder;

    modport master (output cv_note, output cv_pitch, input cv_adder);
    modport slave  (input cv_note, input cv_pitch, output cv_adder);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set req bit strictly after ptr, with wrap.
module rr_pick #(
    parameter int  NVOICES = 8,
    localparam int VW      = $clog2(NVOICES)
) (
    input  logic [NVOICES-1:0] req,
    input  logic [VW-1:0]      ptr,
    output logic               found,
    output logic [VW-1:0]      idx
);
    logic [VW-1:0] k;

    // Walk from farthest to nearest so the nearest candidate is the last write.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int i = NVOICES; i >= 1; i--) begin
            k = VW'((int'(ptr) + i) % NVOICES);
            if (req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end
endmodule

// File: rtl/dds_voice_scheduler.sv
// Time-shares one note/pitch-to-DDS converter among NVOICES voices, converting dirty
// voices round-robin and latching each result into that voice's phase-increment slot.
module dds_voice_scheduler
    import synth_pkg::*;
#(
    parameter int  NVOICES = 8,
    parameter int  SETTLE  = 7,
    localparam int VW      = $clog2(NVOICES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NVOICES*NOTE_W-1:0]  voice_note,
    input  logic [NVOICES-1:0]         voice_gate,
    input  logic [PITCH_W-1:0]         pitch,
    dds_voice_scheduler_if.master      cv,
    output logic [NVOICES*ADDER_W-1:0] voice_adder,
    output logic                       upd_valid,
    output logic [VW-1:0]              upd_voice,
    output logic                       busy
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_DRIVE   = DRIVE;
    localparam logic [1:0] ST_WAIT    = WAIT;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;

    logic [NVOICES-1:0][NOTE_W-1:0]  note_in, note_sh;
    logic [NVOICES-1:0][ADDER_W-1:0] adder_q;
    logic [NVOICES-1:0]              gate_sh, dirty, set_mask, clr_mask, req;
    logic [PITCH_W-1:0]              pitch_sh;
    logic [1:0]                      state;
    logic [VW-1:0]                   sel, rr_ptr, pick_idx;
    logic [CW-1:0]                   cnt;
    logic                            pick_found, sel_stale;

    assign note_in     = voice_note;
    assign voice_adder = adder_q;

    always_comb begin
        set_mask = voice_gate & ~gate_sh;
        for (int k = 0; k < NVOICES; k++)
            if (note_in[k] != note_sh[k]) set_mask[k] = 1'b1;
        if (pitch != pitch_sh) set_mask = '1;
    end

    // cv_note/cv_pitch double as the snapshot of what was sent to the converter.
    assign sel_stale = (note_in[sel] != cv.cv_note) || (pitch != cv.cv_pitch);

    always_comb begin
        clr_mask = '0;
        if (state == ST_CAPTURE && !sel_stale) clr_mask[sel] = 1'b1;
    end

    // Fresh changes are eligible in the same cycle so an idle scheduler reacts immediately.
    assign req = (dirty | set_mask) & voice_gate;

    rr_pick #(.NVOICES(NVOICES)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sel         <= '0;
            cnt         <= '0;
            rr_ptr      <= VW'(NVOICES - 1);
            dirty       <= '1;
            note_sh     <= note_in;
            pitch_sh    <= pitch;
            gate_sh     <= voice_gate;
            cv.cv_note  <= '0;
            cv.cv_pitch <= PITCH_CENTRE;
            busy        <= 1'b0;
            upd_valid   <= 1'b0;
            upd_voice   <= '0;
            adder_q     <= '0;
        end else begin
            note_sh   <= note_in;
            pitch_sh  <= pitch;
            gate_sh   <= voice_gate;
            dirty     <= (dirty & ~clr_mask) | set_mask;
            upd_valid <= 1'b0;
            case (state)
                ST_IDLE: if (pick_found) begin
                    sel         <= pick_idx;
                    cv.cv_note  <= note_in[pick_idx];
                    cv.cv_pitch <= pitch;
                    busy        <= 1'b1;
                    state       <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    cnt   <= CW'(SETTLE - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) state <= ST_CAPTURE;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_CAPTURE: begin
                    adder_q[sel] <= cv.cv_adder;
                    upd_valid    <= 1'b1;
                    upd_voice    <= sel;
                    rr_ptr       <= sel;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
